// File: rtl/sigma_delta_dac.sv
// First-order single-bit sigma-delta DAC with a one-deep sample holding register.
// Define SIGMA_DELTA_DAC_DITHER_EN to add LFSR carry-in dither to the modulator.
module sigma_delta_dac #(
  parameter int OVERSAMPLE_RATE = 256,
  parameter int DAC_BITLEN      = 16,
  parameter bit SIGNED_INPUT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_BITLEN-1:0] dac_input,
  input  logic                  dac_valid,
  output logic                  dac_ready,
  output logic                  dac_output,
  output logic                  dac_underrun
);
  localparam int PW = $clog2(OVERSAMPLE_RATE);
  localparam logic [DAC_BITLEN-1:0] MIDSCALE   = {1'b1, {(DAC_BITLEN-1){1'b0}}};
  localparam logic [DAC_BITLEN-1:0] IN_FLIP    = SIGNED_INPUT ? MIDSCALE : '0;
  localparam logic [PW-1:0]         LAST_PHASE = PW'(OVERSAMPLE_RATE - 1);

  typedef struct packed {
    logic                  full;
    logic [DAC_BITLEN-1:0] data;
  } hold_t;

  logic [PW-1:0]         phase;
  hold_t                 hold;
  logic [DAC_BITLEN-1:0] active;
  logic [DAC_BITLEN:0]   acc;
  logic                  run;
  logic [DAC_BITLEN-1:0] sample;
  logic                  hs;
  logic                  boundary;
  logic                  cin;
  logic [DAC_BITLEN:0]   acc_sum;

  // Signed samples become offset binary on capture so the modulator is unipolar.
  assign sample     = dac_input ^ IN_FLIP;
  assign dac_ready  = run & ~hold.full;
  assign hs         = dac_valid & dac_ready;
  assign boundary   = (phase == LAST_PHASE);
  assign acc_sum    = {1'b0, acc[DAC_BITLEN-1:0]} + {1'b0, active} + {{DAC_BITLEN{1'b0}}, cin};
  assign dac_output = acc[DAC_BITLEN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase        <= '0;
      hold         <= '0;
      active       <= MIDSCALE;
      acc          <= '0;
      run          <= 1'b0;
      dac_underrun <= 1'b0;
    end else begin
      run          <= 1'b1;
      phase        <= phase + PW'(1);
      acc          <= acc_sum;
      dac_underrun <= 1'b0;
      if (boundary) begin
        if (hold.full) begin
          active    <= hold.data;
          hold.full <= 1'b0;
        end else if (hs) begin
          active <= sample;
        end else begin
          dac_underrun <= 1'b1;
        end
      end else if (hs) begin
        hold <= '{full: 1'b1, data: sample};
      end
    end
  end

`ifdef SIGMA_DELTA_DAC_DITHER_EN
  // Maximal-length x^16+x^14+x^13+x^11+1; nonzero seed keeps it out of the lock-up state.
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign cin = lfsr[0];
`else
  assign cin = 1'b0;
`endif

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Scoreboard bench for sigma_delta_dac: unsigned and signed instances share stimulus;
// expected PDM bits come from cumulative-sum density arithmetic.
module tb_sigma_delta_dac;
  localparam int OSR = 256;
  localparam int N   = 16;
  localparam logic [15:0] MID = 16'h8000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dac_input = '0;
  logic        dac_valid = 1'b0;
  logic        rdy_u, out_u, und_u;
  logic        rdy_s, out_s, und_s;

  always #5 clk = ~clk;

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .dac_input(dac_input), .dac_valid(dac_valid),
    .dac_ready(rdy_u), .dac_output(out_u), .dac_underrun(und_u));

  sigma_delta_dac #(.OVERSAMPLE_RATE(OSR), .DAC_BITLEN(N), .SIGNED_INPUT(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .dac_input(dac_input), .dac_valid(dac_valid),
    .dac_ready(rdy_s), .dac_output(out_s), .dac_underrun(und_s));

  typedef struct packed {
    logic out_u;
    logic out_s;
    logic und;
    logic rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: period-level sample handling, output bit = change in floor(sum/2^N).
  int          m_phase;
  bit          m_run;
  bit          m_full;
  logic [15:0] m_hold;
  logic [15:0] m_act_u, m_act_s;
  longint      m_sum_u, m_sum_s;

  task automatic model_reset();
    m_phase = 0;
    m_run   = 1'b0;
    m_full  = 1'b0;
    m_hold  = '0;
    m_act_u = MID;
    m_act_s = MID;
    m_sum_u = 0;
    m_sum_s = 0;
  endtask

  task automatic load(input logic [15:0] raw);
    m_act_u = raw;
    m_act_s = raw ^ 16'h8000;
  endtask

  task automatic step(input bit r, input bit v, input logic [15:0] d);
    exp_t   e;
    bit     hs;
    longint nu, ns;
    @(negedge clk);
    rst       = r;
    dac_valid = v;
    dac_input = d;
    e = '0;
    if (!r) begin
      model_reset();
    end else begin
      hs = v && m_run && !m_full;
      nu = m_sum_u + longint'(m_act_u);
      ns = m_sum_s + longint'(m_act_s);
      e.out_u = ((nu >> N) != (m_sum_u >> N));
      e.out_s = ((ns >> N) != (m_sum_s >> N));
      m_sum_u = nu;
      m_sum_s = ns;
      if (m_phase == OSR-1) begin
        if (m_full) begin
          load(m_hold);
          m_full = 1'b0;
        end else if (hs) begin
          load(d);
        end else begin
          e.und = 1'b1;
        end
      end else if (hs) begin
        m_hold = d;
        m_full = 1'b1;
      end
      m_phase = (m_phase + 1) % OSR;
      m_run   = 1'b1;
      e.rdy   = m_run && !m_full;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_until(input int ph);
    int guard = 0;
    while (m_phase != ph && guard < 2*OSR) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
  endtask

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%0b exp=%0b", name, $time, got, want);
    end
  endtask

  // Monitor: every edge presents a PDM bit; compare against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_unsigned", out_u, e.out_u);
      chk("out_signed",   out_s, e.out_s);
      chk("underrun_u",   und_u, e.und);
      chk("underrun_s",   und_s, e.und);
      chk("ready_u",      rdy_u, e.rdy);
      chk("ready_s",      rdy_s, e.rdy);
    end
  end

  initial begin
    int w;
    bit r;
    model_reset();
    repeat (3) step(1'b0, 1'b0, '0);
    // Idle after reset: midscale alternation and periodic underrun.
    repeat (2*OSR + 20) step(1'b1, 1'b0, '0);
    // Quarter scale streamed continuously.
    repeat (3*OSR) step(1'b1, 1'b1, 16'h4000);
    // Zero, then full scale, then 0xC000 (quarter scale on the signed instance).
    repeat (2*OSR) step(1'b1, 1'b1, 16'h0000);
    repeat (3*OSR) step(1'b1, 1'b1, 16'hFFFF);
    repeat (2*OSR) step(1'b1, 1'b1, 16'hC000);
    // Starve for a period, then present a sample exactly on the boundary (bypass).
    repeat (2*OSR) step(1'b1, 1'b0, '0);
    idle_until(OSR-1);
    step(1'b1, 1'b1, 16'h2000);
    repeat (2*OSR) step(1'b1, 1'b0, '0);
    // Buffer a sample mid-period, then reset for 3 cycles: sample must be lost.
    idle_until(100);
    step(1'b1, 1'b1, 16'h1234);
    repeat (3) step(1'b0, 1'b0, '0);
    repeat (OSR + 20) step(1'b1, 1'b0, '0);
    // Random traffic with occasional resets.
    repeat (6*OSR) begin
      r = ($urandom_range(0, 599) != 0);
      step(r, ($urandom_range(0, 3) == 0), 16'($urandom));
    end
    repeat (OSR) step(1'b1, 1'b1, 16'($urandom));
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
